msk_and_hpc3_seq: RTL and testbench

//  Stream sequencer around one MSKand_hpc3 gadget. Accepts shared operand pairs and fresh randomness words over

---
 rtl/msk_hpc3_pkg.sv | 27 ++
 rtl/MSKand_hpc3.sv | 61 ++++++
 rtl/msk_shares_fifo.sv | 60 ++++++
 rtl/msk_and_hpc3_seq.sv | 116 +++++++++++
 tb/tb_msk_and_hpc3_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msk_hpc3_pkg.sv
// Shared definitions for the masked-AND stream sequencer.
//   D_DEFAULT    default number of shares
//   hpc3_rnd_w   fresh randomness bits consumed by one HPC3 AND
//   fifo_ptr_w   pointer width for a FIFO of a given depth
//   fifo_occ_w   occupancy width (holds 0..depth)
//   pair_idx     linear index of share pair (i,j), i<j, within d shares
package msk_hpc3_pkg;

  localparam int D_DEFAULT = 2;

  function automatic int hpc3_rnd_w(input int d);
    return d * (d - 1);
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int fifo_occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int pair_idx(input int i, input int j, input int d);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/MSKand_hpc3.sv
// HPC3 masked AND gadget, one register stage (latency 1).
//   clk_i    clock
//   ina_i    sharing of a (d shares)
//   inb_i    sharing of b (d shares)
//   rnd_i    fresh randomness, two bits per share pair: r at 2p, r' at 2p+1
//   out_c_o  sharing of a&b, valid one cycle after the inputs
// Every cross term a_i*b_j is refreshed by r_ij before it is registered, and
// the complementary term (~a_i & r_ij) ^ r'_ij is registered separately so
// the two only combine after the register. r and r' are shared by (i,j) and
// (j,i), so they cancel in the XOR of all output shares.
module MSKand_hpc3
  import msk_hpc3_pkg::*;
#(
  parameter int d = D_DEFAULT
) (
  input  logic                     clk_i,
  input  logic [d-1:0]             ina_i,
  input  logic [d-1:0]             inb_i,
  input  logic [hpc3_rnd_w(d)-1:0] rnd_i,
  output logic [d-1:0]             out_c_o
);

  logic [d-1:0]          z_d, z_q;
  logic [d-1:0][d-1:0]   u_d, u_q;
  logic [d-1:0][d-1:0]   v_d, v_q;

  always_comb begin
    z_d = '0;
    u_d = '0;
    v_d = '0;
    for (int i = 0; i < d; i++) begin
      z_d[i] = ina_i[i] & inb_i[i];
      for (int j = 0; j < d; j++) begin
        if (j != i) begin
          u_d[i][j] = ina_i[i] &
                      (inb_i[j] ^ rnd_i[2*pair_idx((i < j) ? i : j, (i < j) ? j : i, d)]);
          v_d[i][j] = (~ina_i[i] & rnd_i[2*pair_idx((i < j) ? i : j, (i < j) ? j : i, d)]) ^
                      rnd_i[2*pair_idx((i < j) ? i : j, (i < j) ? j : i, d) + 1];
        end
      end
    end
  end

  // No reset: the sequencer only consumes these registers when its own
  // stage-1 valid (which is reset) says they hold a live result.
  always_ff @(posedge clk_i) begin
    z_q <= z_d;
    u_q <= u_d;
    v_q <= v_d;
  end

  always_comb begin
    out_c_o = z_q;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        out_c_o[i] = out_c_o[i] ^ u_q[i][j] ^ v_q[i][j];
      end
    end
  end

endmodule

// File: rtl/msk_shares_fifo.sv
// Small circular FIFO holding {tag, shares} words verbatim.
//   clk_i/rst_i   clock, asynchronous active-high reset
//   push_i        write push_data_i at the tail (caller guarantees not full)
//   pop_i         drop the head entry (caller guarantees not empty)
//   head_o        current head entry, read straight from storage registers
//   occ_o         number of valid entries, 0..DEPTH
// Push and pop in the same cycle both take effect and leave occ_o unchanged.
module msk_shares_fifo
  import msk_hpc3_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 3,
  localparam int OCC_W = fifo_occ_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [OCC_W-1:0] occ_o
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/msk_and_hpc3_seq.sv
// Stream sequencer around one HPC3 masked AND.
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      operand pair handshake (in_a, in_b shares, in_tag)
//   rnd_valid/rnd_ready    randomness word handshake (rnd_data)
//   out_valid/out_ready    result handshake (out_data shares, out_tag)
//   ops_cnt                ANDs issued since reset, saturating
//   starve_cnt             cycles blocked only by missing randomness, saturating
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; producers hold valid and payload stable until accepted. Operand
// and randomness words are always consumed together (in_ready == rnd_ready).
// Credit counts the result FIFO plus the op in the gadget stage, so an issued
// op always has a FIFO slot waiting and the gadget never stalls mid-flight.
module msk_and_hpc3_seq
  import msk_hpc3_pkg::*;
#(
  parameter int d     = D_DEFAULT,
  parameter int TAG_W = 4,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [d-1:0]             in_a,
  input  logic [d-1:0]             in_b,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     rnd_valid,
  output logic                     rnd_ready,
  input  logic [hpc3_rnd_w(d)-1:0] rnd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [d-1:0]             out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [CNT_W-1:0]         ops_cnt,
  output logic [CNT_W-1:0]         starve_cnt
);

  localparam int RND_W = hpc3_rnd_w(d);
  localparam int OCC_W = fifo_occ_w(DEPTH);
  localparam int FW    = TAG_W + d;

  logic             credit;
  logic             issue;
  logic [d-1:0]     gadget_a, gadget_b, gadget_c;
  logic [RND_W-1:0] gadget_r;
  logic             s1_valid_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [OCC_W-1:0] occ;
  logic [FW-1:0]    head;
  logic             pop;
  logic [CNT_W-1:0] ops_cnt_q, ops_cnt_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Registered state only: out_ready has no combinational path to in_ready.
  assign credit = (int'(occ) + int'(s1_valid_q)) < DEPTH;
  assign issue  = in_valid & rnd_valid & credit & ~rst;

  assign in_ready  = issue;
  assign rnd_ready = issue;

  // Idle cycles present all-zero shares and randomness to the gadget, so a
  // randomness word is only ever seen by the gadget in the cycle it is consumed.
  assign gadget_a = in_a     & {d{issue}};
  assign gadget_b = in_b     & {d{issue}};
  assign gadget_r = rnd_data & {RND_W{issue}};

  MSKand_hpc3 #(.d(d)) u_and (
    .clk_i   (clk),
    .ina_i   (gadget_a),
    .inb_i   (gadget_b),
    .rnd_i   (gadget_r),
    .out_c_o (gadget_c)
  );

  always_comb begin
    ops_cnt_d = ops_cnt_q;
    if (issue && (ops_cnt_q != '1)) ops_cnt_d = ops_cnt_q + 1'b1;
    starve_cnt_d = starve_cnt_q;
    if (in_valid && credit && !rnd_valid && (starve_cnt_q != '1))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      ops_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      s1_valid_q   <= issue;
      s1_tag_q     <= in_tag;
      ops_cnt_q    <= ops_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign pop = out_valid & out_ready;

  msk_shares_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (s1_valid_q),
    .push_data_i ({s1_tag_q, gadget_c}),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign out_valid  = (occ != '0);
  assign out_data   = head[d-1:0];
  assign out_tag    = head[FW-1:d];
  assign ops_cnt    = ops_cnt_q;
  assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_msk_and_hpc3_seq.sv
module tb_msk_and_hpc3_seq;

  localparam int D     = 2;
  localparam int TAG_W = 4;
  localparam int DEPTH = 3;
  localparam int CNT_W = 16;
  localparam int RND_W = D * (D - 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0, in_ready;
  logic [D-1:0]     in_a = '0, in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             rnd_valid = 1'b0, rnd_ready;
  logic [RND_W-1:0] rnd_data = '0;
  logic             out_valid, out_ready = 1'b0;
  logic [D-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] ops_cnt, starve_cnt;

  msk_and_hpc3_seq #(.d(D), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .ops_cnt(ops_cnt), .starve_cnt(starve_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- scoreboard ----------------
  // Reference: each accepted op yields {tag, a&b} with a, b the XOR of the
  // input shares; results leave in acceptance order; at most DEPTH ops may be
  // accepted but not yet delivered; a reset discards everything outstanding.
  logic [TAG_W:0] exp_q[$];
  int outstanding = 0;
  int n_acc = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      n_cmp++;
      if (in_ready !== rnd_ready || (in_ready && !(in_valid && rnd_valid))) begin
        n_fail++;
        $display("FAIL rnd_pairing: in_ready=%b rnd_ready=%b in_valid=%b rnd_valid=%b",
                 in_ready, rnd_ready, in_valid, rnd_valid);
      end
      if (in_ready === 1'b1) begin
        n_cmp++;
        if (outstanding >= DEPTH) begin
          n_fail++;
          $display("FAIL credit: accepted with %0d outstanding, limit %0d", outstanding, DEPTH);
        end
        exp_q.push_back({in_tag, (^in_a) & (^in_b)});
        outstanding++;
        n_acc++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got tag=%h val=%b, expected no result", out_tag, ^out_data);
        end else begin
          logic [TAG_W:0] e;
          e = exp_q.pop_front();
          if ({out_tag, ^out_data} !== e) begin
            n_fail++;
            $display("FAIL result: got tag=%h val=%b, expected tag=%h val=%b",
                     out_tag, ^out_data, e[TAG_W:1], e[0]);
          end
          outstanding--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_valid  = 1'b0;
    rnd_valid = 1'b0;
  endtask

  task automatic drive_op();
    in_a     = D'($urandom);
    in_b     = D'($urandom);
    in_tag   = TAG_W'($urandom);
    rnd_data = RND_W'($urandom);
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_op();
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, rnd_ready, out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready/rnd_ready/out_valid=%b expected 000",
               {in_ready, rnd_ready, out_valid});
    end
    n_cmp++;
    if ({out_data, out_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%b out_tag=%h expected 0", out_data, out_tag);
    end
    n_cmp++;
    if (ops_cnt !== '0 || starve_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: ops=%0d starve=%0d expected 0", ops_cnt, starve_cnt);
    end
    n_cmp++;
    if ({dut.gadget_a, dut.gadget_b, dut.gadget_r} !== '0) begin
      n_fail++;
      $display("FAIL reset_gadget_in: %b expected 0", {dut.gadget_a, dut.gadget_b, dut.gadget_r});
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    out_ready = 1'b1;
    in_a = 2'b10; in_b = 2'b01; rnd_data = 2'b11; in_tag = 4'hA;
    in_valid = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t0: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t1: out_valid=%b expected 0", out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || (^out_data) !== 1'b1 || out_tag !== 4'hA) begin
      n_fail++;
      $display("FAIL single_t2: out_valid=%b val=%b tag=%h expected 1/1/a",
               out_valid, ^out_data, out_tag);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t3: out_valid=%b expected 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_op();
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready: op %0d in_ready=%b expected 1", k, in_ready);
      end
      @(posedge clk); #1;
    end
    drive_idle();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (ops_cnt !== 16'd8 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: ops_cnt=%0d pending=%0d out_valid=%b expected 8/0/0",
               ops_cnt, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic took;
    apply_reset();
    out_ready = 1'b0;
    drive_op();
    took = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      took = in_ready;
      if (took) acc++;
      @(posedge clk); #1;
      if (took) drive_op();
    end
    n_cmp++;
    if (acc != DEPTH || took !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_fill: accepted=%0d last_ready=%b expected %0d/0", acc, took, DEPTH);
    end
    drive_idle();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || ops_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL bp_drain: pending=%0d out_valid=%b ops_cnt=%0d expected 0/0/3",
               exp_q.size(), out_valid, ops_cnt);
    end
  endtask

  task automatic test_starve();
    apply_reset();
    out_ready = 1'b1;
    drive_op();
    rnd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || {dut.gadget_a, dut.gadget_b, dut.gadget_r} !== '0) begin
        n_fail++;
        $display("FAIL starve_idle: cycle %0d in_ready=%b gadget_in=%b expected 0/0",
                 k, in_ready, {dut.gadget_a, dut.gadget_b, dut.gadget_r});
      end
      @(posedge clk); #1;
      in_a = D'($urandom); in_b = D'($urandom); rnd_data = RND_W'($urandom);
    end
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (starve_cnt !== 16'd5 || ops_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL starve_cnt: starve=%0d ops=%0d expected 5/0", starve_cnt, ops_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_op();
      @(posedge clk); #1;
    end
    drive_idle();
    // Two results sit in the FIFO and one is in the gadget stage now.
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || {out_data, out_tag} !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: out_valid=%b data=%b tag=%h in_ready=%b expected all 0",
               out_valid, out_data, out_tag, in_ready);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0 || ops_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_drop: out_valid cycles=%0d ops_cnt=%0d expected 0/0", seen, ops_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int base;
    int cycles = 0;
    logic took = 1'b0;
    apply_reset();
    base = n_acc;
    while ((n_acc - base) < 10000 && cycles < 60000) begin
      if (!in_valid || took) begin
        in_a     = D'($urandom);
        in_b     = D'($urandom);
        in_tag   = TAG_W'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      rnd_data  = RND_W'($urandom);
      rnd_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      cycles++;
    end
    drive_idle();
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if ((n_acc - base) < 10000) begin
      n_fail++;
      $display("FAIL rand_budget: accepted=%0d in %0d cycles, required 10000", n_acc - base, cycles);
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: pending=%0d out_valid=%b expected 0/0", exp_q.size(), out_valid);
    end
    n_cmp++;
    if (int'(ops_cnt) != (n_acc - base)) begin
      n_fail++;
      $display("FAIL rand_ops_cnt: ops_cnt=%0d expected %0d", ops_cnt, n_acc - base);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_starve();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
